// File: rtl/imm_decode_ctrl_pkg.sv
// Shared definitions for the decode-stage instruction skid buffer.
// Contents:
//   imm_type_e - immediate-generator format codes (R=0 .. J=5)
//   OPC_*      - RV32I major opcodes recognised by the decoder
//   state_e    - RUN / TRAP controller states
//   entry_t    - one buffered instruction with its pre-decoded type
package imm_decode_ctrl_pkg;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_type_dec.sv
// Combinational opcode decoder: maps a 7-bit major opcode to the immediate
// format used by the immediate generator, flagging opcodes it does not know.
// Ports:
//   opcode   in  [6:0]  instruction bits [6:0]
//   imm_type out [2:0]  immediate format (R for unknown opcodes)
//   illegal  out        opcode is not a recognised RV32I major opcode
module imm_type_dec
  import imm_decode_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = IMM_R;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP:                       imm_type = IMM_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type = IMM_I;
      OPC_STORE:                    imm_type = IMM_S;
      OPC_BRANCH:                   imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:           imm_type = IMM_U;
      OPC_JAL:                      imm_type = IMM_J;
      default: begin
        imm_type = IMM_R;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage skid buffer: a DEPTH-entry FIFO between fetch and EX that
// pre-decodes the immediate format on entry. An illegal head instruction
// stalls the buffer in TRAP until the trap handler acknowledges it, which
// discards that entry.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    fetch-side handshake; in_instr/in_pc payload
//   flush                redirect: empties the buffer on the next edge
//   out_valid/out_ready  EX-side handshake; out_instr/out_pc head payload
//   imm_type, imm_field  immediate format and out_instr[31:7]
//   illegal, trap_ack    head is illegal / trap handler consumed it
module imm_decode_ctrl
  import imm_decode_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  imm_type,
  output logic [24:0] imm_field,
  output logic        illegal,
  input  logic        trap_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  state_e           r_state;
  state_e           w_state_nxt;

  logic [2:0] w_dec_type;
  logic       w_dec_illegal;
  entry_t     w_head;
  logic       w_has_head;
  logic       w_push;
  logic       w_pop;
  logic       w_trap_pop;

  imm_type_dec u_imm_type_dec (
    .opcode   (in_instr[6:0]),
    .imm_type (w_dec_type),
    .illegal  (w_dec_illegal)
  );

  assign w_head     = r_mem[r_rd_ptr];
  assign w_has_head = (r_count != '0);

  // rst_n gates in_ready directly so fetch sees "not ready" during reset,
  // even though the cleared count would otherwise report space.
  assign in_ready  = rst_n && (r_count < FULL_CNT) && !flush && (r_state != ST_TRAP);
  assign out_valid = w_has_head && (r_state == ST_RUN) && !w_head.illegal;
  assign illegal   = w_has_head && w_head.illegal;

  // Outputs are forced to zero when empty so stale storage never leaks out.
  assign out_instr = w_has_head ? w_head.instr    : '0;
  assign out_pc    = w_has_head ? w_head.pc       : '0;
  assign imm_type  = w_has_head ? w_head.imm_type : '0;
  assign imm_field = out_instr[31:7];

  assign w_push     = in_valid && in_ready;
  assign w_trap_pop = (r_state == ST_TRAP) && trap_ack;
  assign w_pop      = (out_valid && out_ready) || w_trap_pop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_has_head && w_head.illegal) w_state_nxt = ST_TRAP;
      ST_TRAP: if (trap_ack) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
    if (flush) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{instr: in_instr, pc: in_pc,
                           imm_type: w_dec_type, illegal: w_dec_illegal};
    end
  end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
module tb_imm_decode_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  imm_type;
  logic [24:0] imm_field;
  logic        illegal;
  logic        trap_ack;

  always #5 clk = ~clk;

  imm_decode_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .imm_type  (imm_type),
    .imm_field (imm_field),
    .illegal   (illegal),
    .trap_ack  (trap_ack)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of buffered instructions plus a "trapped" flag.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          m_trap;
  int          type_tab[bit [6:0]];
  logic [31:0] got[$];
  logic [31:0] sent[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit head_ill();
    if (q.size() == 0) return 1'b0;
    return !type_tab.exists(q[0].instr[6:0]);
  endfunction

  function automatic logic [2:0] head_type();
    if (q.size() == 0) return 3'd0;
    if (!type_tab.exists(q[0].instr[6:0])) return 3'd0;
    return 3'(type_tab[q[0].instr[6:0]]);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy, input logic tack);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    trap_ack  = tack;
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    bit   has;
    has = (q.size() > 0);
    if (has) h = q[0];
    else     h = '{instr: 32'h0, pc: 32'h0};
    check({tag, ".in_ready"},  in_ready,  (q.size() < DEPTH) && !flush && !m_trap);
    check({tag, ".out_valid"}, out_valid, has && !m_trap && !head_ill());
    check({tag, ".illegal"},   illegal,   has && head_ill());
    check({tag, ".out_instr"}, out_instr, h.instr);
    check({tag, ".out_pc"},    out_pc,    h.pc);
    check({tag, ".imm_field"}, imm_field, h.instr[31:7]);
    check({tag, ".imm_type"},  imm_type,  head_type());
  endtask

  // Called shortly before a rising edge; applies that edge to the model.
  task automatic advance();
    bit has_ill, ovld, irdy, pop, push, was_trap, fl, tack;
    ent_t e;
    has_ill = head_ill();
    ovld    = (q.size() > 0) && !m_trap && !has_ill;
    irdy    = (q.size() < DEPTH) && !flush && !m_trap;
    pop     = (ovld && out_ready) || (m_trap && trap_ack);
    push    = in_valid && irdy;
    fl      = flush;
    tack    = trap_ack;
    e       = '{instr: in_instr, pc: in_pc};
    if (out_valid && out_ready) got.push_back(out_instr);
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_trap = 1'b0;
    end else begin
      was_trap = m_trap;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
      m_trap = was_trap ? !tack : has_ill;
    end
    #1;
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input logic ordy, input logic tack);
    drive(v, ins, pc, fl, ordy, tack);
    #4;
    check_model(tag);
    advance();
  endtask

  // Offer one instruction; acc reports whether it was taken on this edge.
  task automatic offer(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, output bit acc);
    drive(1'b1, ins, pc, 1'b0, ordy, 1'b0);
    #4;
    check_model(tag);
    acc = (q.size() < DEPTH) && !m_trap;
    if (acc) sent.push_back(ins);
    advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  in_ready,  0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".illegal"},   illegal,   0);
    check({tag, ".out_instr"}, out_instr, 0);
    check({tag, ".out_pc"},    out_pc,    0);
    check({tag, ".imm_field"}, imm_field, 0);
    check({tag, ".imm_type"},  imm_type,  0);
  endtask

  task automatic compare_order(input string tag);
    check({tag, ".count"}, got.size(), sent.size());
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      check($sformatf("%s.order%0d", tag, i), got[i], sent[i]);
  endtask

  logic [6:0]  legal_opc [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  logic [31:0] b2b [4] = '{32'h00100113, 32'h002081B3, 32'h00312023, 32'h00000463};

  initial begin
    int          idx;
    bit          acc;
    logic [31:0] r;
    logic [6:0]  opc;

    type_tab[7'h33] = 0;
    type_tab[7'h13] = 1;
    type_tab[7'h03] = 1;
    type_tab[7'h67] = 1;
    type_tab[7'h23] = 2;
    type_tab[7'h63] = 3;
    type_tab[7'h37] = 4;
    type_tab[7'h17] = 4;
    type_tab[7'h6F] = 5;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    q.delete();
    m_trap = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // addi x1, x0, 5 at PC 0: next cycle presents an I-type with imm bits
    step("addi_push", 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #4;
    check_model("addi_out");
    check("addi_vld", out_valid, 1);
    check("addi_type", imm_type, 1);
    check("addi_imm", imm_field, 25'h000A001);
    check("addi_pc", out_pc, 32'h0);
    advance();
    step("addi_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Back-to-back pushes with EX stalled, then drain in order
    got.delete();
    sent.delete();
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      offer("b2b_fill", b2b[idx], 32'h1000 + 32'(idx * 4), 1'b0, acc);
      if (acc) idx++;
    end
    check("b2b_accepted", idx, 2);
    for (int k = 0; k < 12; k++) begin
      if (idx < 4) begin
        offer("b2b_drain", b2b[idx], 32'h1000 + 32'(idx * 4), 1'b1, acc);
        if (acc) idx++;
      end else begin
        step("b2b_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
    end
    compare_order("b2b");

    // Illegal instruction: stall until trap_ack discards it
    step("ill_push", 1'b1, 32'hFFFFFFFF, 32'h100, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #4;
    check_model("ill_head");
    check("ill_flag", illegal, 1);
    check("ill_vld", out_valid, 0);
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #4;
    check_model("ill_trap");
    check("ill_rdy", in_ready, 0);
    check("ill_flag2", illegal, 1);
    advance();
    step("ill_ack", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #4;
    check_model("ill_after");
    check("ill_clr", illegal, 0);
    check("ill_vld2", out_valid, 0);
    check("ill_empty", out_instr, 0);
    advance();

    // Flush on a full buffer while fetch offers a new instruction
    step("fl_fill0", 1'b1, 32'h00A00513, 32'h200, 1'b0, 1'b0, 1'b0);
    step("fl_fill1", 1'b1, 32'h00B00593, 32'h204, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00C00613, 32'h208, 1'b1, 1'b0, 1'b0);
    #4;
    check_model("fl_edge");
    check("fl_rdy", in_ready, 0);
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #4;
    check_model("fl_after");
    check("fl_vld", out_valid, 0);
    check("fl_instr", out_instr, 0);
    check("fl_rdy2", in_ready, 1);
    advance();

    // Full buffer with continuous push and pop; pointers wrap repeatedly
    got.delete();
    sent.delete();
    offer("wrap_fill", 32'h00100093, 32'h300, 1'b0, acc);
    offer("wrap_fill", 32'h00200113, 32'h304, 1'b0, acc);
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      r = {20'(k + 1), 5'(k), 7'h13};
      offer("wrap_pp", r, 32'h400 + 32'(k * 4), 1'b1, acc);
    end
    for (int k = 0; k < 6; k++)
      step("wrap_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    compare_order("wrap");

    // Randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      r = $urandom();
      if ($urandom_range(0, 4) == 0) opc = r[6:0];
      else opc = legal_opc[$urandom_range(0, 8)];
      step("rnd", ($urandom_range(0, 3) != 0), {r[31:7], opc}, $urandom(),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset mid-stream
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    #4;
    advance();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #4;
    advance();
    step("rst_fill0", 1'b1, 32'h00D00693, 32'h500, 1'b0, 1'b0, 1'b0);
    step("rst_fill1", 1'b1, 32'hFFFFFFFF, 32'h504, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00E00713, 32'h508, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    m_trap = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    step("rst_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step("rst_push", 1'b1, 32'h00F00793, 32'h600, 1'b0, 1'b1, 1'b0);
    step("rst_out", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
